// File: rtl/pc_ctrl_if.sv
// rtl/pc_ctrl_if.sv - PC controller bus: PC register, instruction fetch and redirect signals
// Optional trap port present only when PC_TRAP_EN is defined.
interface pc_ctrl_if;
  logic [31:0] pc_q;
  logic        pc_ena;
  logic [31:0] pc_d;
  logic        imem_req;
  logic        imem_ack;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jmp;
  logic [31:0] jmp_target;
`ifdef PC_TRAP_EN
  logic        trap;
`endif
  logic        fetch_valid;

`ifdef PC_TRAP_EN
  modport master (
    input  pc_q, imem_ack, stall, br_taken, br_target, jmp, jmp_target, trap,
    output pc_ena, pc_d, imem_req, fetch_valid
  );
  modport slave (
    output pc_q, imem_ack, stall, br_taken, br_target, jmp, jmp_target, trap,
    input  pc_ena, pc_d, imem_req, fetch_valid
  );
`else
  modport master (
    input  pc_q, imem_ack, stall, br_taken, br_target, jmp, jmp_target,
    output pc_ena, pc_d, imem_req, fetch_valid
  );
  modport slave (
    output pc_q, imem_ack, stall, br_taken, br_target, jmp, jmp_target,
    input  pc_ena, pc_d, imem_req, fetch_valid
  );
`endif
endinterface

// File: rtl/pc_ctrl.sv
// rtl/pc_ctrl.sv - program counter sequencer: boot, fetch handshake, stall hold and redirect selection
// Optional trap redirect enabled by defining PC_TRAP_EN.
module pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0040_0004
) (
  input  logic     clk,
  input  logic     rst,
  pc_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;

  // Redirect priority level: 0 none, 1 branch, 2 jump, 3 trap.
  logic [1:0]  req_lvl;
  logic [31:0] req_tgt;
  logic [1:0]  pend_lvl;
  logic [31:0] pend_tgt;
  logic [31:0] next_pc;

`ifndef PC_TRAP_EN
  wire unused_trap_pc = ^TRAP_PC;
`endif

  // Highest-priority redirect currently requested, target word-aligned.
  always_comb begin
    req_lvl = 2'd0;
    req_tgt = 32'h0;
`ifdef PC_TRAP_EN
    if (bus.trap) begin
      req_lvl = 2'd3;
      req_tgt = TRAP_PC & ~32'h3;
    end else
`endif
    if (bus.jmp) begin
      req_lvl = 2'd2;
      req_tgt = bus.jmp_target & ~32'h3;
    end else if (bus.br_taken) begin
      req_lvl = 2'd1;
      req_tgt = bus.br_target & ~32'h3;
    end
  end

  // Redirects seen while a fetch is outstanding are held until the PC can move;
  // only a strictly higher-priority request replaces the one already held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_lvl <= 2'd0;
      pend_tgt <= 32'h0;
    end else if (state == FETCH) begin
      if (req_lvl > pend_lvl) begin
        pend_lvl <= req_lvl;
        pend_tgt <= req_tgt;
      end
    end else if (bus.pc_ena) begin
      pend_lvl <= 2'd0;
    end
  end

  // Next PC: held redirect, then a live redirect, then sequential with natural wrap.
  always_comb begin
    if (pend_lvl != 2'd0)     next_pc = pend_tgt;
    else if (req_lvl != 2'd0) next_pc = req_tgt;
    else                      next_pc = bus.pc_q + 32'd4;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= BOOT;
    else     state <= state_nxt;
  end

  // Next-state logic; ack is only meaningful while fetching.
  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    state_nxt = FETCH;
      FETCH:   state_nxt = bus.imem_ack ? ISSUE : FETCH;
      ISSUE:   state_nxt = bus.stall ? HOLD : FETCH;
      HOLD:    state_nxt = bus.stall ? HOLD : FETCH;
      default: state_nxt = BOOT;
    endcase
  end

  // Outputs are forced quiet while reset is held so nothing leaks out of BOOT.
  always_comb begin
    bus.pc_ena      = 1'b0;
    bus.pc_d        = 32'h0;
    bus.imem_req    = 1'b0;
    bus.fetch_valid = 1'b0;
    if (!rst) begin
      case (state)
        BOOT: begin
          bus.pc_ena = 1'b1;
          bus.pc_d   = RESET_PC;
        end
        FETCH: begin
          bus.imem_req = 1'b1;
        end
        ISSUE: begin
          bus.fetch_valid = (pend_lvl == 2'd0);
          bus.pc_ena      = ~bus.stall;
          bus.pc_d        = next_pc;
        end
        HOLD: begin
          bus.pc_ena = ~bus.stall;
          bus.pc_d   = next_pc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_ctrl.sv
// tb/tb_pc_ctrl.sv - self-checking bench for pc_ctrl with transaction-level reference model
module tb_pc_ctrl;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam logic [31:0] TRAP_PC  = 32'h0040_0004;
`ifdef PC_TRAP_EN
  localparam int MAXK = 3;
`else
  localparam int MAXK = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  pc_ctrl_if bus();
  pc_ctrl #(.RESET_PC(RESET_PC), .TRAP_PC(TRAP_PC)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // The PC register the controller drives.
  logic [31:0] pc_reg = 32'h0;
  always @(posedge clk) if (bus.pc_ena) pc_reg <= bus.pc_d;
  assign bus.pc_q = pc_reg;

  // Effective target of a redirect kind (1 br, 2 jmp, 3 trap).
  function automatic logic [31:0] eff(input int k, input logic [31:0] t);
    if (k == 3) return TRAP_PC & ~32'h3;
    return t & ~32'h3;
  endfunction

  // Kind k is the highest asserted request; all lower ones are asserted too, with junk targets.
  task automatic set_redir(input int k, input logic [31:0] t);
    bus.br_taken   = (k >= 1);
    bus.br_target  = (k == 1) ? t : $urandom;
    bus.jmp        = (k >= 2);
    bus.jmp_target = (k == 2) ? t : $urandom;
`ifdef PC_TRAP_EN
    bus.trap       = (k >= 3);
`endif
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drives one complete fetch starting at a FETCH cycle; only collects observations.
  task automatic run_fetch(input int delay, input logic [7:0] fk, input logic [127:0] ft,
                           input int nstall, input int dk, input logic [31:0] dt,
                           output logic [31:0] o_pc, output logic o_req_f, output logic o_ena_f,
                           output logic o_fv, output logic o_req_i, output logic o_ena_early,
                           output logic o_ena, output logic [31:0] o_pc_d);
    o_pc = 32'h0; o_req_f = 1'b1; o_ena_f = 1'b0; o_ena_early = 1'b0;
    o_fv = 1'b0; o_req_i = 1'b0; o_ena = 1'b0; o_pc_d = 32'h0;
    for (int i = 0; i <= delay; i++) begin
      if (i < delay) set_redir(int'(fk[i*2 +: 2]), ft[i*32 +: 32]);
      else           set_redir(0, 32'h0);
      bus.imem_ack = (i == delay);
      bus.stall    = 1'($urandom);
      @(negedge clk);
      if (i == 0) o_pc = bus.pc_q;
      o_req_f = o_req_f & bus.imem_req;
      o_ena_f = o_ena_f | bus.pc_ena;
      next_cycle();
    end
    for (int h = 0; h <= nstall; h++) begin
      bus.imem_ack = 1'($urandom);
      bus.stall    = (h < nstall);
      if (h < nstall) set_redir($urandom_range(0, MAXK), $urandom);
      else            set_redir(dk, dt);
      @(negedge clk);
      if (h == 0) begin
        o_fv    = bus.fetch_valid;
        o_req_i = bus.imem_req;
      end
      if (h < nstall) o_ena_early = o_ena_early | bus.pc_ena;
      else begin
        o_ena  = bus.pc_ena;
        o_pc_d = bus.pc_d;
      end
      next_cycle();
    end
    set_redir(0, 32'h0);
    bus.imem_ack = 1'b0;
    bus.stall    = 1'b0;
  endtask

  logic [31:0] r_pc, r_pc_d;
  logic        r_req_f, r_ena_f, r_fv, r_req_i, r_ena_early, r_ena;

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    vectors++; if (bus.pc_ena !== 1'b0) begin miscompares++; $display("FAIL reset_pc_ena got %b expected 0", bus.pc_ena); end
    vectors++; if (bus.pc_d !== 32'h0) begin miscompares++; $display("FAIL reset_pc_d got %h expected 0", bus.pc_d); end
    vectors++; if (bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL reset_imem_req got %b expected 0", bus.imem_req); end
    vectors++; if (bus.fetch_valid !== 1'b0) begin miscompares++; $display("FAIL reset_fetch_valid got %b expected 0", bus.fetch_valid); end
    next_cycle();
  endtask

  task automatic test_boot();
    logic [31:0] exp_pc;
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (bus.pc_ena !== 1'b1) begin miscompares++; $display("FAIL boot_pc_ena got %b expected 1", bus.pc_ena); end
    vectors++; if (bus.pc_d !== RESET_PC) begin miscompares++; $display("FAIL boot_pc_d got %h expected %h", bus.pc_d, RESET_PC); end
    next_cycle();
    exp_pc = RESET_PC;
    for (int n = 0; n < 3; n++) begin
      run_fetch(1, 8'h0, 128'h0, 0, 0, 32'h0, r_pc, r_req_f, r_ena_f, r_fv, r_req_i, r_ena_early, r_ena, r_pc_d);
      vectors++; if (r_pc !== exp_pc) begin miscompares++; $display("FAIL boot_fetch_pc got %h expected %h", r_pc, exp_pc); end
      vectors++; if (r_fv !== 1'b1) begin miscompares++; $display("FAIL boot_fetch_valid got %b expected 1", r_fv); end
      vectors++; if (r_req_f !== 1'b1 || r_ena_f !== 1'b0) begin miscompares++; $display("FAIL boot_fetch_phase got req=%b ena=%b expected req=1 ena=0", r_req_f, r_ena_f); end
      exp_pc = exp_pc + 32'd4;
      vectors++; if (r_ena !== 1'b1 || r_pc_d !== exp_pc) begin miscompares++; $display("FAIL boot_next_pc got ena=%b pc_d=%h expected ena=1 pc_d=%h", r_ena, r_pc_d, exp_pc); end
    end
  endtask

  task automatic test_wrap();
    run_fetch(0, 8'h0, 128'h0, 0, 2, 32'hFFFF_FFFC, r_pc, r_req_f, r_ena_f, r_fv, r_req_i, r_ena_early, r_ena, r_pc_d);
    vectors++; if (r_pc_d !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_setup got %h expected fffffffc", r_pc_d); end
    run_fetch(0, 8'h0, 128'h0, 0, 0, 32'h0, r_pc, r_req_f, r_ena_f, r_fv, r_req_i, r_ena_early, r_ena, r_pc_d);
    vectors++; if (r_pc !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_fetch_pc got %h expected fffffffc", r_pc); end
    vectors++; if (r_ena !== 1'b1 || r_pc_d !== 32'h0) begin miscompares++; $display("FAIL wrap_pc_d got ena=%b pc_d=%h expected ena=1 pc_d=0", r_ena, r_pc_d); end
  endtask

  task automatic test_pending();
    run_fetch(3, {2'd0, 2'd0, 2'd0, 2'd1}, {96'h0, 32'h0040_0103}, 0, 0, 32'h0,
              r_pc, r_req_f, r_ena_f, r_fv, r_req_i, r_ena_early, r_ena, r_pc_d);
    vectors++; if (r_fv !== 1'b0) begin miscompares++; $display("FAIL pend_br_fetch_valid got %b expected 0", r_fv); end
    vectors++; if (r_pc_d !== 32'h0040_0100) begin miscompares++; $display("FAIL pend_br_pc_d got %h expected 00400100", r_pc_d); end
    run_fetch(3, {2'd0, 2'd1, 2'd2, 2'd1}, {32'h0, 32'h0000_9999, 32'h0000_7777, 32'h0000_5555}, 0, 0, 32'h0,
              r_pc, r_req_f, r_ena_f, r_fv, r_req_i, r_ena_early, r_ena, r_pc_d);
    vectors++; if (r_pc_d !== 32'h0000_7774) begin miscompares++; $display("FAIL pend_overwrite got %h expected 00007774", r_pc_d); end
    run_fetch(2, {4'd0, 2'd1, 2'd2}, {64'h0, 32'h0000_3333, 32'h0000_1110}, 2, 0, 32'h0,
              r_pc, r_req_f, r_ena_f, r_fv, r_req_i, r_ena_early, r_ena, r_pc_d);
    vectors++; if (r_ena_early !== 1'b0 || r_pc_d !== 32'h0000_1110) begin miscompares++; $display("FAIL pend_ignore_lower got early=%b pc_d=%h expected early=0 pc_d=00001110", r_ena_early, r_pc_d); end
  endtask

  task automatic test_priority();
    run_fetch(0, 8'h0, 128'h0, 0, 2, 32'h0012_3458, r_pc, r_req_f, r_ena_f, r_fv, r_req_i, r_ena_early, r_ena, r_pc_d);
    vectors++; if (r_fv !== 1'b1 || r_pc_d !== 32'h0012_3458) begin miscompares++; $display("FAIL prio_jmp_over_br got fv=%b pc_d=%h expected fv=1 pc_d=00123458", r_fv, r_pc_d); end
`ifdef PC_TRAP_EN
    run_fetch(0, 8'h0, 128'h0, 0, 3, 32'h0, r_pc, r_req_f, r_ena_f, r_fv, r_req_i, r_ena_early, r_ena, r_pc_d);
    vectors++; if (r_pc_d !== 32'h0040_0004) begin miscompares++; $display("FAIL prio_trap got %h expected 00400004", r_pc_d); end
`endif
  endtask

  task automatic test_stall();
    run_fetch(1, 8'h0, 128'h0, 4, 0, 32'h0, r_pc, r_req_f, r_ena_f, r_fv, r_req_i, r_ena_early, r_ena, r_pc_d);
    vectors++; if (r_ena_early !== 1'b0) begin miscompares++; $display("FAIL stall_hold_ena got %b expected 0", r_ena_early); end
    vectors++; if (r_ena !== 1'b1 || r_pc_d !== r_pc + 32'd4) begin miscompares++; $display("FAIL stall_release got ena=%b pc_d=%h expected ena=1 pc_d=%h", r_ena, r_pc_d, r_pc + 32'd4); end
  endtask

  task automatic test_reset_mid_fetch();
    bus.imem_ack = 1'b0;
    @(negedge clk);
    vectors++; if (bus.imem_req !== 1'b1) begin miscompares++; $display("FAIL rmf_in_fetch got %b expected 1", bus.imem_req); end
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    vectors++; if (bus.imem_req !== 1'b0 || bus.pc_ena !== 1'b0) begin miscompares++; $display("FAIL rmf_reset got req=%b ena=%b expected 0 0", bus.imem_req, bus.pc_ena); end
    next_cycle();
    rst = 1'b0;
    bus.imem_ack = 1'b1;
    @(negedge clk);
    vectors++; if (bus.fetch_valid !== 1'b0 || bus.pc_ena !== 1'b1 || bus.pc_d !== RESET_PC) begin miscompares++; $display("FAIL rmf_boot got fv=%b ena=%b pc_d=%h expected fv=0 ena=1 pc_d=%h", bus.fetch_valid, bus.pc_ena, bus.pc_d, RESET_PC); end
    next_cycle();
    bus.imem_ack = 1'b0;
    run_fetch(1, 8'h0, 128'h0, 0, 0, 32'h0, r_pc, r_req_f, r_ena_f, r_fv, r_req_i, r_ena_early, r_ena, r_pc_d);
    vectors++; if (r_pc !== RESET_PC || r_fv !== 1'b1) begin miscompares++; $display("FAIL rmf_restart got pc=%h fv=%b expected pc=%h fv=1", r_pc, r_fv, RESET_PC); end
  endtask

  task automatic test_random();
    logic [31:0]  model_pc, ptgt, exp_d, dt;
    logic [7:0]   fk;
    logic [127:0] ft;
    int           plvl, delay, nstall, dk, k;
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    next_cycle();
    model_pc = RESET_PC;
    for (int n = 0; n < 40; n++) begin
      delay  = $urandom_range(0, 3);
      nstall = $urandom_range(0, 3);
      dk     = $urandom_range(0, MAXK);
      dt     = $urandom;
      for (int s = 0; s < 4; s++) begin
        fk[s*2 +: 2] = 2'($urandom_range(0, MAXK));
        ft[s*32 +: 32] = $urandom;
      end
      plvl = 0; ptgt = 32'h0;
      for (int i = 0; i < delay; i++) begin
        k = int'(fk[i*2 +: 2]);
        if (k > plvl) begin plvl = k; ptgt = eff(k, ft[i*32 +: 32]); end
      end
      if (plvl != 0)    exp_d = ptgt;
      else if (dk != 0) exp_d = eff(dk, dt);
      else              exp_d = model_pc + 32'd4;
      run_fetch(delay, fk, ft, nstall, dk, dt, r_pc, r_req_f, r_ena_f, r_fv, r_req_i, r_ena_early, r_ena, r_pc_d);
      vectors++; if (r_pc !== model_pc) begin miscompares++; $display("FAIL rnd_fetch_pc[%0d] got %h expected %h", n, r_pc, model_pc); end
      vectors++; if (r_req_f !== 1'b1 || r_ena_f !== 1'b0) begin miscompares++; $display("FAIL rnd_fetch_phase[%0d] got req=%b ena=%b expected 1 0", n, r_req_f, r_ena_f); end
      vectors++; if (r_fv !== (plvl == 0) || r_req_i !== 1'b0) begin miscompares++; $display("FAIL rnd_issue[%0d] got fv=%b req=%b expected fv=%b req=0", n, r_fv, r_req_i, (plvl == 0)); end
      vectors++; if (r_ena_early !== 1'b0) begin miscompares++; $display("FAIL rnd_hold_ena[%0d] got %b expected 0", n, r_ena_early); end
      vectors++; if (r_ena !== 1'b1 || r_pc_d !== exp_d) begin miscompares++; $display("FAIL rnd_next_pc[%0d] got ena=%b pc_d=%h expected ena=1 pc_d=%h", n, r_ena, r_pc_d, exp_d); end
      model_pc = exp_d;
    end
  endtask

  initial begin
    bus.imem_ack = 1'b0;
    bus.stall    = 1'b0;
    set_redir(0, 32'h0);
    test_reset();
    test_boot();
    test_wrap();
    test_pending();
    test_priority();
    test_stall();
    test_reset_mid_fetch();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/pc_ctrl.md
PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0040_0000, SHALL be the boot fetch address loaded after reset.
REQ-002 Parameter TRAP_PC, default 32'h0040_0004, SHALL be the trap vector address (used only when PC_TRAP_EN is defined).
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  SHALL be the reset: asynchronous, active-high.
REQ-005 pc_q  in  32  SHALL be the current value held in the PC register.
REQ-006 pc_ena  out  1  SHALL be the PC register load enable.
REQ-007 pc_d  out  32  SHALL be the next-PC value presented to the PC register.
REQ-008 imem_req  out  1  SHALL be the instruction-fetch request; it is held until imem_ack.
REQ-009 imem_ack  in  1  SHALL be the fetch-complete strobe for the current pc_q.
REQ-010 stall  in  1  SHALL be the datapath hold request.
REQ-011 br_taken / br_target  in  1 / 32  SHALL be the branch redirect request and its target.
REQ-012 jmp / jmp_target  in  1 / 32  SHALL be the jump redirect request and its target.
REQ-013 trap  in  1  SHALL be the trap request; this port exists only with PC_TRAP_EN.
REQ-014 fetch_valid  out  1  SHALL be a one-cycle pulse marking the instruction at pc_q as valid for decode.

Function
REQ-015 States SHALL be BOOT, FETCH, ISSUE and HOLD, encoded in 2 bits.
REQ-016 BOOT: assert pc_ena=1 with pc_d=RESET_PC for exactly one cycle, then go to FETCH.
REQ-017 FETCH: imem_req=1. Stay in FETCH while imem_ack=0; on imem_ack=1 go to ISSUE.
REQ-018 ISSUE: imem_req=0 and fetch_valid=1, unless a redirect was pending (REQ-022). If stall=0, pc_ena=1 and go to FETCH; if stall=1, go to HOLD.
REQ-019 HOLD: pc_ena=0 and fetch_valid=0. Stay in HOLD while stall=1; when stall=0, pc_ena=1 and go to FETCH.
REQ-020 Next-PC selection SHALL follow this priority: trap (TRAP_PC) > jmp (jmp_target) > br_taken (br_target) > sequential (pc_q+4).
REQ-021 pc_q+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000). Redirect targets SHALL have bits [1:0] forced to 0.
REQ-022 A redirect raised in FETCH before imem_ack SHALL be latched with its target into a pending register. On ack, that ISSUE cycle suppresses fetch_valid, and the next pc_d is the pending target.
REQ-023 A higher-priority redirect arriving while one is pending SHALL overwrite it; a lower-priority one SHALL be ignored.
REQ-024 Redirect inputs present during ISSUE or HOLD SHALL be applied directly on the cycle pc_ena asserts and SHALL NOT be latched.
REQ-025 pc_ena SHALL never assert in FETCH, so the PC is stable for the whole outstanding fetch.
REQ-026 imem_ack outside FETCH SHALL be ignored.
REQ-027 Latency: ack to fetch_valid SHALL be 1 cycle. With stall=0 and ack every cycle, throughput SHALL be one instruction per 2 cycles.

Reset
REQ-028 rst=1 SHALL immediately force state=BOOT, pc_ena=0, pc_d=0, imem_req=0, fetch_valid=0 and clear the pending register.
REQ-029 A reset during an outstanding fetch SHALL abandon that fetch; a late imem_ack SHALL have no effect.
REQ-030 The first rising edge after rst deasserts SHALL execute the BOOT action.

Configuration
REQ-031 With PC_TRAP_EN defined, the trap port SHALL exist, has the highest redirect priority, and is latched as pending like the other redirects.
REQ-032 Without PC_TRAP_EN, the trap port and the TRAP_PC logic SHALL be absent, and selection SHALL be jmp > br > sequential.

Verification
REQ-033 Reset then release, ack one cycle after each req -> pc_d=32'h0040_0000 with pc_ena once; fetch_valid at 0x00400000, then 0x00400004, 0x00400008.
REQ-034 pc_q=32'hFFFF_FFFC, ack, stall=0 -> pc_d=32'h0000_0000 with pc_ena=1 in ISSUE.
REQ-035 br_taken=1 with br_target=32'h0040_0103 during FETCH, ack delayed 3 cycles -> fetch_valid stays 0 in that ISSUE; pc_d=32'h0040_0100.
REQ-036 jmp and br_taken asserted in the same ISSUE cycle -> pc_d=jmp_target.
REQ-037 stall=1 for 4 cycles after an ack -> HOLD for 4 cycles with pc_ena=0, then pc_ena=1 with pc_q+4.
REQ-038 rst pulsed mid-FETCH, then imem_ack -> no fetch_valid; the BOOT sequence restarts at RESET_PC. With PC_TRAP_EN, trap with jmp -> pc_d=32'h0040_0004.
